uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one UART byte transmitter between N_REQ requesters. It accepts bytes over per-requester valid/ready handshakes and issues one tx_start pulse per byte. It then tracks the transmitter's busy flag until the frame completes, and inserts a programmable idle gap before the next grant. It sits between the application channels and the serial transmitter, mirroring the receiver on the other side of the line.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_tx_arbiter_if.sv | 14 +
 rtl/uart_tx_arbiter_rr_pick.sv | 19 +
 rtl/uart_tx_arbiter.sv | 100 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state codes, tag header and default byte width for the UART transmit arbiter
// Optional macro UART_ARB_TAG_EN adds the tag-frame states TAG_ACK, TAG_DONE and SEND.
package uart_pkg;
  localparam int DW_DEF = 8;
  localparam logic [3:0] TAG_HDR = 4'hA;
  typedef logic [2:0] state_t;
  localparam state_t IDLE = 3'd0, LOAD = 3'd1, WAIT_ACK = 3'd2, WAIT_DONE = 3'd3, GAP = 3'd4;
`ifdef UART_ARB_TAG_EN
  localparam state_t TAG_ACK = 3'd5, TAG_DONE = 3'd6, SEND = 3'd7;
`endif
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshakes plus transmitter byte port shared by the arbiter
// req_valid/req_data/req_ready: per-requester byte handshake (byte i at [i*DATA_W +: DATA_W])
// tx_data/tx_start/tx_busy: byte, start pulse and frame-busy flag of the serial transmitter
// master: arbiter side; slave: requesters and transmitter side
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(parameter int N_REQ = 4, parameter int DATA_W = DW_DEF);
  logic [N_REQ-1:0] req_valid, req_ready;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [DATA_W-1:0] tx_data;
  logic tx_start, tx_busy;
  modport master(input req_valid, req_data, tx_busy, output req_ready, tx_data, tx_start);
  modport slave(output req_valid, req_data, tx_busy, input req_ready, tx_data, tx_start);
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first valid index at or above ptr with wrap
// valid: request vector; ptr: search start; grant: winning index; any: some request is valid
module rr_pick #(parameter int N = 4, parameter int IW = $clog2(N)) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any
);
  assign any = |valid;
  always_comb begin
    logic [IW-1:0] j;
    grant = '0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % N);
      if (valid[j]) grant = j;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART byte transmitter between N_REQ requesters
// clc: clock; res: async active-low reset; bus: uart_tx_arbiter_if.master (handshakes + tx port)
// grant_id: current/last granted index; active: grant through gap expiry; ack_err: sticky no-busy error
// Optional macro UART_ARB_TAG_EN: each grant sends a tag byte {TAG_HDR, index} before the data byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DW_DEF,
  parameter int GAP_CYC = 16,
  parameter int ACK_TO  = 8
) (
  input  logic                     clc,
  input  logic                     res,
  uart_tx_arbiter_if.master        bus,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     active,
  output logic                     ack_err
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2((GAP_CYC > ACK_TO ? GAP_CYC : ACK_TO) + 1);
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TO - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);
  localparam state_t AFTER_TX = GAP_CYC > 0 ? GAP : IDLE;
  state_t st;
  logic [IW-1:0] ptr, pick, gq;
  logic any, load;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] txq, pdata, first;
  rr_pick #(.N(N_REQ)) u_pick (.valid(bus.req_valid), .ptr(ptr), .grant(pick), .any(any));
  assign pdata = bus.req_data[pick*DATA_W +: DATA_W];
  // a valid dropped between IDLE and LOAD aborts the grant instead of capturing stale data
  assign load = st == LOAD && any;
`ifdef UART_ARB_TAG_EN
  localparam state_t FIRST_ACK = TAG_ACK;
  logic [DATA_W-1:0] dq;
  assign first = {TAG_HDR, (DATA_W-4)'(pick)};
  assign bus.tx_start = load || st == SEND;
  always_ff @(posedge clc or negedge res)
    if (!res) dq <= '0;
    else if (load) dq <= pdata;
`else
  localparam state_t FIRST_ACK = WAIT_ACK;
  assign first = pdata;
  assign bus.tx_start = load;
`endif
  assign bus.tx_data = load ? first : txq;
  assign bus.req_ready = load ? N_REQ'(1) << pick : '0;
  assign grant_id = load ? pick : gq;
  assign active = st != IDLE;
  always_ff @(posedge clc or negedge res)
    if (!res) begin
      st <= IDLE;
      ptr <= '0;
      gq <= '0;
      cnt <= '0;
      txq <= '0;
      ack_err <= 1'b0;
    end else begin
      case (st)
        IDLE: st <= any ? LOAD : IDLE;
        LOAD: if (any) begin
          st <= FIRST_ACK;
          gq <= pick;
          ptr <= IW'((int'(pick) + 1) % N_REQ);
          txq <= first;
          cnt <= '0;
        end else st <= IDLE;
        WAIT_ACK: if (bus.tx_busy) st <= WAIT_DONE;
          else if (cnt == ACK_LAST) begin
            ack_err <= 1'b1;
            st <= AFTER_TX;
            cnt <= GAP_LD;
          end else cnt <= cnt + 1'b1;
        WAIT_DONE: if (!bus.tx_busy) begin
          st <= AFTER_TX;
          cnt <= GAP_LD;
        end
        GAP: if (cnt == '0) st <= IDLE;
          else cnt <= cnt - 1'b1;
`ifdef UART_ARB_TAG_EN
        TAG_ACK: if (bus.tx_busy) st <= TAG_DONE;
          else if (cnt == ACK_LAST) begin
            ack_err <= 1'b1;
            st <= SEND;
            txq <= dq;
          end else cnt <= cnt + 1'b1;
        TAG_DONE: if (!bus.tx_busy) begin
          st <= SEND;
          txq <= dq;
        end
        SEND: begin
          st <= WAIT_ACK;
          cnt <= '0;
        end
`endif
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench with requester, transmitter and monitor models
module tb_uart_tx_arbiter;
  localparam int N = 4, W = 8, GAP = 16, ACK = 8;
  logic clc = 1'b0, res = 1'b0;
  logic [1:0] grant_id;
  logic active, ack_err;
  int checks = 0, errors = 0;
  int cyc = 0, fall_cyc = 0, err_cyc = -1, busy_len = 10, bleft = 0, sb = 0;
  logic busy_en = 1'b1, pbusy = 1'b0, perr = 1'b0, multi = 1'b0;
  int qw [N] = '{default: 0};
  int qr [N] = '{default: 0};
  int rc [N] = '{default: 0};
  int rb [N] = '{default: 0};
  logic [W-1:0] qd [N][8];
  logic [W-1:0] ld [$];
  logic [1:0] lg [$];
  int lc [$];

  uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();
  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .GAP_CYC(GAP), .ACK_TO(ACK)) dut (
    .clc(clc), .res(res), .bus(bus), .grant_id(grant_id), .active(active), .ack_err(ack_err)
  );

  always #5 clc = ~clc;

  // requesters: each holds valid/data until it sees its req_ready at a clock edge
  initial begin
    logic [N-1:0] r;
    bus.req_valid = '0;
    bus.req_data = '0;
    forever begin
      @(posedge clc);
      r = bus.req_ready;
      #1;
      for (int i = 0; i < N; i++) begin
        if (r[i] && qw[i] > qr[i]) qr[i]++;
        bus.req_valid[i] = qw[i] > qr[i];
        bus.req_data[i*W +: W] = qd[i][qr[i] % 8];
      end
    end
  end

  // transmitter: busy rises the cycle after tx_start and stays high busy_len cycles
  initial begin
    logic s;
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clc);
      s = bus.tx_start;
      #1;
      if (!res) begin
        bus.tx_busy = 1'b0;
        bleft = 0;
      end else if (busy_en && s) begin
        bus.tx_busy = 1'b1;
        bleft = busy_len;
      end else if (bleft > 0) begin
        bleft--;
        if (bleft == 0) bus.tx_busy = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clc);
    cyc++;
    if (bus.tx_start) begin
      ld.push_back(bus.tx_data);
      lg.push_back(grant_id);
      lc.push_back(cyc);
    end
    for (int i = 0; i < N; i++) rc[i] += int'(bus.req_ready[i]);
    if ($countones(bus.req_ready) > 1) multi = 1'b1;
    if (pbusy && !bus.tx_busy) fall_cyc = cyc;
    if (ack_err && !perr) err_cyc = cyc;
    pbusy = bus.tx_busy;
    perr = ack_err;
  end

  function automatic int pend();
    int s = 0;
    for (int i = 0; i < N; i++) s += qw[i] - qr[i];
    return s;
  endfunction

  task automatic mark();
    sb = ld.size();
    for (int i = 0; i < N; i++) rb[i] = rc[i];
  endtask

  task automatic push(input int i, input logic [W-1:0] d);
    qd[i][qw[i] % 8] = d;
    qw[i]++;
  endtask

  task automatic drop(input int i);
    qw[i] = qr[i];
  endtask

  task automatic do_reset();
    @(negedge clc);
    res = 1'b0;
    for (int i = 0; i < N; i++) drop(i);
    repeat (2) @(negedge clc);
    res = 1'b1;
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    int t = 0;
    while (ld.size() - sb < n && t < budget) begin
      @(negedge clc);
      t++;
    end
    checks++;
    if (ld.size() - sb < n) begin
      errors++;
      $display("FAIL %s: %0d tx_start pulses seen, %0d required", tag, ld.size() - sb, n);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int t = 0;
    @(negedge clc);
    while ((active || pend() > 0) && t < budget) begin
      @(negedge clc);
      t++;
    end
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL %s: active %b after %0d cycles, required 0", tag, active, budget);
    end
  endtask

  task automatic wait_busy(input int budget, input string tag);
    int t = 0;
    while (!bus.tx_busy && t < budget) begin
      @(negedge clc);
      t++;
    end
    checks++;
    if (bus.tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s: tx_busy %b, required 1", tag, bus.tx_busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clc);
    checks += 6;
    if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", bus.tx_start); end
    if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL rst_ready: got %h want 0", bus.req_ready); end
    if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", bus.tx_data); end
    if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant: got %0d want 0", grant_id); end
    if (active !== 1'b0) begin errors++; $display("FAIL rst_active: got %b want 0", active); end
    if (ack_err !== 1'b0) begin errors++; $display("FAIL rst_ackerr: got %b want 0", ack_err); end
    res = 1'b1;
    @(negedge clc);
  endtask

  task automatic test_single();
    mark();
    busy_en = 1'b1;
    busy_len = 100;
    push(2, 8'h5A);
    push(2, 8'h77);
    wait_starts(2, 400, "single_starts");
    checks += 5;
    if (ld[sb] !== 8'h5A) begin errors++; $display("FAIL single_data0: got %h want 5a", ld[sb]); end
    if (lg[sb] !== 2'd2) begin errors++; $display("FAIL single_grant0: got %0d want 2", lg[sb]); end
    if (ld[sb+1] !== 8'h77) begin errors++; $display("FAIL single_data1: got %h want 77", ld[sb+1]); end
    if (lg[sb+1] !== 2'd2) begin errors++; $display("FAIL single_grant1: got %0d want 2", lg[sb+1]); end
    if (lc[sb+1] - fall_cyc < GAP || lc[sb+1] - fall_cyc > GAP + 3) begin
      errors++;
      $display("FAIL single_gap: got %0d cycles busy-fall to next start, want %0d..%0d", lc[sb+1] - fall_cyc, GAP, GAP + 3);
    end
    wait_idle(400, "single_idle");
    checks += 2;
    if (rc[2] - rb[2] !== 2) begin errors++; $display("FAIL single_ready: got %0d pulses want 2", rc[2] - rb[2]); end
    if (ld.size() - sb !== 2) begin errors++; $display("FAIL single_count: got %0d starts want 2", ld.size() - sb); end
  endtask

  task automatic test_rr();
    logic [1:0] eg [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] ed [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    do_reset();
    mark();
    busy_len = 3;
    push(0, 8'h10);
    push(0, 8'h10);
    push(1, 8'h11);
    push(2, 8'h12);
    push(3, 8'h13);
    wait_starts(5, 300, "rr_starts");
    for (int k = 0; k < 5; k++) begin
      checks += 2;
      if (lg[sb+k] !== eg[k]) begin errors++; $display("FAIL rr_grant%0d: got %0d want %0d", k, lg[sb+k], eg[k]); end
      if (ld[sb+k] !== ed[k]) begin errors++; $display("FAIL rr_data%0d: got %h want %h", k, ld[sb+k], ed[k]); end
    end
    wait_idle(200, "rr_idle");
  endtask

  task automatic test_drop();
    do_reset();
    mark();
    busy_len = 20;
    push(2, 8'h22);
    wait_starts(1, 20, "drop_first");
    wait_busy(10, "drop_busy1");
    push(1, 8'h31);
    push(3, 8'h33);
    wait_starts(2, 100, "drop_second");
    wait_busy(10, "drop_busy2");
    drop(1);
    push(0, 8'h40);
    wait_starts(3, 100, "drop_third");
    wait_idle(100, "drop_idle");
    checks += 6;
    if (lg[sb+1] !== 2'd3) begin errors++; $display("FAIL drop_grant1: got %0d want 3", lg[sb+1]); end
    if (ld[sb+1] !== 8'h33) begin errors++; $display("FAIL drop_data1: got %h want 33", ld[sb+1]); end
    if (lg[sb+2] !== 2'd0) begin errors++; $display("FAIL drop_grant2: got %0d want 0", lg[sb+2]); end
    if (ld[sb+2] !== 8'h40) begin errors++; $display("FAIL drop_data2: got %h want 40", ld[sb+2]); end
    if (rc[1] - rb[1] !== 0) begin errors++; $display("FAIL drop_ready1: got %0d pulses want 0", rc[1] - rb[1]); end
    if (ld.size() - sb !== 3) begin errors++; $display("FAIL drop_count: got %0d starts want 3", ld.size() - sb); end
  endtask

  task automatic test_ackto();
    do_reset();
    mark();
    checks++;
    if (ack_err !== 1'b0) begin errors++; $display("FAIL ackto_pre: got %b want 0", ack_err); end
    busy_en = 1'b0;
    push(1, 8'h55);
    push(2, 8'h66);
    wait_starts(2, 100, "ackto_starts");
    checks += 5;
    if (err_cyc - lc[sb] !== ACK + 1) begin errors++; $display("FAIL ackto_time: got %0d cycles start to ack_err want %0d", err_cyc - lc[sb], ACK + 1); end
    if (lc[sb+1] - lc[sb] !== ACK + GAP + 2) begin errors++; $display("FAIL ackto_next: got %0d cycles between starts want %0d", lc[sb+1] - lc[sb], ACK + GAP + 2); end
    if (lg[sb+1] !== 2'd2) begin errors++; $display("FAIL ackto_grant: got %0d want 2", lg[sb+1]); end
    if (ld[sb+1] !== 8'h66) begin errors++; $display("FAIL ackto_data: got %h want 66", ld[sb+1]); end
    if (ack_err !== 1'b1) begin errors++; $display("FAIL ackto_sticky: got %b want 1", ack_err); end
    wait_idle(100, "ackto_idle");
  endtask

  task automatic test_reset_mid();
    mark();
    busy_en = 1'b1;
    busy_len = 50;
    push(2, 8'h99);
    wait_starts(1, 60, "mid_first");
    wait_busy(10, "mid_busy");
    repeat (3) @(negedge clc);
    #2 res = 1'b0;
    #1;
    checks += 6;
    if (active !== 1'b0) begin errors++; $display("FAIL mid_active: got %b want 0", active); end
    if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL mid_start: got %b want 0", bus.tx_start); end
    if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL mid_ready: got %h want 0", bus.req_ready); end
    if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL mid_data: got %h want 00", bus.tx_data); end
    if (grant_id !== 2'd0) begin errors++; $display("FAIL mid_grant: got %0d want 0", grant_id); end
    if (ack_err !== 1'b0) begin errors++; $display("FAIL mid_ackerr: got %b want 0", ack_err); end
    for (int i = 0; i < N; i++) drop(i);
    push(0, 8'hA0);
    push(3, 8'hB3);
    repeat (2) @(negedge clc);
    res = 1'b1;
    wait_starts(3, 200, "mid_after");
    wait_idle(200, "mid_idle");
    checks += 6;
    if (lg[sb+1] !== 2'd0) begin errors++; $display("FAIL mid_grant1: got %0d want 0", lg[sb+1]); end
    if (ld[sb+1] !== 8'hA0) begin errors++; $display("FAIL mid_data1: got %h want a0", ld[sb+1]); end
    if (lg[sb+2] !== 2'd3) begin errors++; $display("FAIL mid_grant2: got %0d want 3", lg[sb+2]); end
    if (ld[sb+2] !== 8'hB3) begin errors++; $display("FAIL mid_data2: got %h want b3", ld[sb+2]); end
    if (rc[2] - rb[2] !== 1) begin errors++; $display("FAIL mid_nodup: got %0d pulses want 1", rc[2] - rb[2]); end
    if (ld.size() - sb !== 3) begin errors++; $display("FAIL mid_count: got %0d starts want 3", ld.size() - sb); end
  endtask

`ifdef UART_ARB_TAG_EN
  task automatic test_tag();
    do_reset();
    mark();
    busy_en = 1'b1;
    busy_len = 5;
    push(3, 8'hC3);
    wait_starts(2, 100, "tag_starts");
    wait_idle(100, "tag_idle");
    checks += 5;
    if (ld[sb] !== 8'hA3) begin errors++; $display("FAIL tag_byte: got %h want a3", ld[sb]); end
    if (ld[sb+1] !== 8'hC3) begin errors++; $display("FAIL tag_data: got %h want c3", ld[sb+1]); end
    if (lg[sb+1] !== 2'd3) begin errors++; $display("FAIL tag_grant: got %0d want 3", lg[sb+1]); end
    if (rc[3] - rb[3] !== 1) begin errors++; $display("FAIL tag_ready: got %0d pulses want 1", rc[3] - rb[3]); end
    if (ld.size() - sb !== 2) begin errors++; $display("FAIL tag_count: got %0d starts want 2", ld.size() - sb); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef UART_ARB_TAG_EN
    test_tag();
`else
    test_single();
    test_rr();
    test_drop();
    test_ackto();
    test_reset_mid();
`endif
    checks++;
    if (multi !== 1'b0) begin errors++; $display("FAIL ready_onehot: got multiple req_ready bits %b want 0", multi); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
